pwm_source_arbiter: RTL

//  Selects which requester drives the left/right motor PWM generators: host bus commands, RC receiver
//  (tank-mixed throttle/steer) or failsafe neutral. Runs a 20 ms frame scheduler and updates widths only
//  at frame boundaries. Enforces host watchdog, RC override switch and pause.

---
 rtl/pwm_arb_pkg.sv | 24 ++
 rtl/pwm_source_arbiter_if.sv | 32 +++
 rtl/pwm_slew_limiter.sv | 48 ++++
 rtl/pwm_source_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pwm_arb_pkg.sv
// rtl/pwm_arb_pkg.sv - shared types, constants and width clamp for the PWM source arbiter
package pwm_arb_pkg;

    typedef enum logic [1:0] {
        FAILSAFE = 2'd0,
        HOST     = 2'd1,
        RC       = 2'd2
    } arb_state_t;

    localparam logic [7:0] NEUTRAL_WIDTH       = 8'd127;
    localparam int         DEFAULT_FRAME_TICKS = 5100;

    // Tank-mix results range from -128 to 383; fold them back onto the 0..255 width scale.
    function automatic logic [7:0] clamp_width(input logic signed [9:0] v);
        if (v[9]) begin
            return 8'd0;
        end else if (v[8]) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/pwm_source_arbiter_if.sv
// rtl/pwm_source_arbiter_if.sv - host/RC request inputs and PWM width outputs of the arbiter
interface pwm_source_arbiter_if;

    logic       pause;
    logic       host_strobe;
    logic [7:0] host_left;
    logic [7:0] host_right;
    logic       rc_valid;
    logic [7:0] rc_throttle;
    logic [7:0] rc_steer;
    logic       rc_mode_valid;
    logic [7:0] rc_mode;
    logic [7:0] width_left;
    logic [7:0] width_right;
    logic [1:0] source;
    logic       frame_start;

    // Requester side: bus registers and RC receivers, observing the selected widths.
    modport master (
        output pause, host_strobe, host_left, host_right,
        output rc_valid, rc_throttle, rc_steer, rc_mode_valid, rc_mode,
        input  width_left, width_right, source, frame_start
    );

    // Arbiter side.
    modport slave (
        input  pause, host_strobe, host_left, host_right,
        input  rc_valid, rc_throttle, rc_steer, rc_mode_valid, rc_mode,
        output width_left, width_right, source, frame_start
    );

endinterface

// File: rtl/pwm_slew_limiter.sv
// rtl/pwm_slew_limiter.sv - per-channel width register with optional rate limit (SLEW_LIMIT_EN)
module pwm_slew_limiter
    import pwm_arb_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en,
    input  logic       snap,
    input  logic [7:0] target,
    output logic [7:0] width
);

`ifdef SLEW_LIMIT_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    localparam logic [7:0] STEP_W = 8'(STEP);

    logic [7:0] diff_up;
    logic [7:0] diff_dn;
    logic [7:0] slewed;

    // Move toward target by at most STEP_W; land exactly on target when closer than that.
    always_comb begin
        diff_up = target - width;
        diff_dn = width - target;
        slewed  = target;
        if ((target > width) && (diff_up > STEP_W)) begin
            slewed = width + STEP_W;
        end else if ((target < width) && (diff_dn > STEP_W)) begin
            slewed = width - STEP_W;
        end
    end

    // Width changes only on frame boundaries; failsafe (snap) and the unlimited build jump directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            width <= NEUTRAL_WIDTH;
        end else if (step_en) begin
            width <= (snap || !SLEW_ON) ? target : slewed;
        end
    end

endmodule

// File: rtl/pwm_source_arbiter.sv
// rtl/pwm_source_arbiter.sv - frame-scheduled host/RC/failsafe PWM source arbiter; optional SLEW_LIMIT_EN
module pwm_source_arbiter
    import pwm_arb_pkg::*;
#(
    parameter int FRAME_TICKS         = DEFAULT_FRAME_TICKS,
    parameter int HOST_TIMEOUT_FRAMES = 25,
    parameter int RC_OVERRIDE_THRESH  = 192,
    parameter int SLEW_STEP           = 8
) (
    input  logic                 clk_255kHz,
    input  logic                 reset,
    pwm_source_arbiter_if.slave  bus
);

    localparam int               CNT_W     = $clog2(FRAME_TICKS);
    localparam int               WD_W      = $clog2(HOST_TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(FRAME_TICKS - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(HOST_TIMEOUT_FRAMES - 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(HOST_TIMEOUT_FRAMES);
    localparam logic [7:0]       RC_THRESH = 8'(RC_OVERRIDE_THRESH);

    logic [CNT_W-1:0] frame_cnt;
    logic             boundary;
    logic             frame_start_q;
    logic [7:0]       host_left_q;
    logic [7:0]       host_right_q;
    logic [WD_W-1:0]  wd_cnt;
    logic             host_alive;
    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             rc_request;
    logic signed [9:0] mix_left;
    logic signed [9:0] mix_right;
    logic [7:0]       target_left;
    logic [7:0]       target_right;
    logic             snap;
    logic [7:0]       width_left_q;
    logic [7:0]       width_right_q;

    assign boundary   = (frame_cnt == LAST_TICK);
    assign rc_request = bus.rc_mode_valid && (bus.rc_mode >= RC_THRESH);

    // Frame counter; frame_start is high in the first cycle of each new frame.
    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            frame_cnt     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= boundary;
            frame_cnt     <= boundary ? '0 : frame_cnt + CNT_W'(1);
        end
    end

    // Host command latch and watchdog; a strobe always wins over the boundary increment.
    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            host_left_q  <= NEUTRAL_WIDTH;
            host_right_q <= NEUTRAL_WIDTH;
            wd_cnt       <= '0;
            host_alive   <= 1'b0;
        end else if (bus.host_strobe) begin
            host_left_q  <= bus.host_left;
            host_right_q <= bus.host_right;
            wd_cnt       <= '0;
            host_alive   <= 1'b1;
        end else if (boundary && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_LAST) begin
                host_alive <= 1'b0;
            end
        end
    end

    // Source state register; it only changes on boundary edges.
    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            state_q <= FAILSAFE;
        end else begin
            state_q <= state_d;
        end
    end

    // Source selection in priority order; an RC override with bad RC data never falls back to host.
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            if (bus.pause) begin
                state_d = FAILSAFE;
            end else if (rc_request) begin
                state_d = bus.rc_valid ? RC : FAILSAFE;
            end else if (host_alive) begin
                state_d = HOST;
            end else begin
                state_d = FAILSAFE;
            end
        end
    end

    // Tank mix of throttle/steer around the 127 centre, in 10-bit signed to keep the overflow visible.
    always_comb begin
        mix_left  = $signed({2'b00, bus.rc_throttle}) + $signed({2'b00, bus.rc_steer}) - 10'sd127;
        mix_right = $signed({2'b00, bus.rc_throttle}) - $signed({2'b00, bus.rc_steer}) + 10'sd127;
    end

    // Width targets for the state being entered at this boundary.
    always_comb begin
        target_left  = NEUTRAL_WIDTH;
        target_right = NEUTRAL_WIDTH;
        snap         = 1'b0;
        case (state_d)
            HOST: begin
                target_left  = host_left_q;
                target_right = host_right_q;
            end
            RC: begin
                target_left  = clamp_width(mix_left);
                target_right = clamp_width(mix_right);
            end
            default: begin
                snap = 1'b1;
            end
        endcase
    end

    pwm_slew_limiter #(.STEP(SLEW_STEP)) u_slew_left (
        .clk     (clk_255kHz),
        .reset   (reset),
        .step_en (boundary),
        .snap    (snap),
        .target  (target_left),
        .width   (width_left_q)
    );

    pwm_slew_limiter #(.STEP(SLEW_STEP)) u_slew_right (
        .clk     (clk_255kHz),
        .reset   (reset),
        .step_en (boundary),
        .snap    (snap),
        .target  (target_right),
        .width   (width_right_q)
    );

    assign bus.width_left  = width_left_q;
    assign bus.width_right = width_right_q;
    assign bus.source      = state_q;
    assign bus.frame_start = frame_start_q;

endmodule
